// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC owner, imem handshake, one-entry skid, redirect drop.
// Optional FETCH_MISALIGN_CHK_EN adds MisalignF for unaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         StallF,
  input  logic         PCSrcE,
  input  logic [31:0]  PCTargetE,
  fetch_unit_if.master imem,
  output logic [31:0]  InstrF,
  output logic [31:0]  PCF,
  output logic [31:0]  PCPlus4F,
  output logic         ValidF
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic         MisalignF
`endif
);

  localparam logic [31:0] AMASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fly_q, fly_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] p4_q, p4_d;
  logic        skv_q, skv_d;
  logic [31:0] ski_q, ski_d;
  logic [31:0] skp_q, skp_d;
  logic        mis_q;
  logic        req;
  logic        busy;

`ifdef FETCH_MISALIGN_CHK_EN
  logic mis_d;
  assign MisalignF = mis_q;
`else
  assign mis_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fly_d   = fly_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pcf_d   = pcf_q;
    p4_d    = p4_q;
    skv_d   = skv_q;
    ski_d   = ski_q;
    skp_d   = skp_q;
`ifdef FETCH_MISALIGN_CHK_EN
    mis_d   = mis_q;
`endif
    req     = 1'b0;
    busy    = 1'b0;

    if (valid_q && !StallF)
      valid_d = 1'b0;
    if (skv_q && !StallF) begin
      valid_d = 1'b1;
      instr_d = ski_q;
      pcf_d   = skp_q;
      p4_d    = skp_q + 32'd4;
      skv_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // a full skid blocks new fetches until it drains
        req = !mis_q && (!skv_q || !StallF);
        if (req && imem.imem_gnt) begin
          state_d = WAIT;
          fly_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          busy    = 1'b1;
        end
      end
      WAIT: begin
        busy = !imem.imem_rvalid;
        if (imem.imem_rvalid) begin
          if (!valid_q || !StallF) begin
            valid_d = 1'b1;
            instr_d = imem.imem_rdata;
            pcf_d   = fly_q;
            p4_d    = fly_q + 32'd4;
            req     = !PCSrcE;
            if (req && imem.imem_gnt) begin
              fly_d = pc_q;
              pc_d  = pc_q + 32'd4;
            end else begin
              state_d = REQ;
            end
          end else begin
            skv_d   = 1'b1;
            ski_d   = imem.imem_rdata;
            skp_d   = fly_q;
            state_d = REQ;
          end
        end
      end
      DROP: begin
        busy = !imem.imem_rvalid;
        if (imem.imem_rvalid)
          state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (PCSrcE) begin
      pc_d    = PCTargetE & AMASK;
      valid_d = 1'b0;
      skv_d   = 1'b0;
      state_d = busy ? DROP : REQ;
`ifdef FETCH_MISALIGN_CHK_EN
      mis_d   = |PCTargetE[1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & AMASK;
      fly_q   <= '0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pcf_q   <= '0;
      p4_q    <= '0;
      skv_q   <= 1'b0;
      ski_q   <= '0;
      skp_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fly_q   <= fly_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pcf_q   <= pcf_d;
      p4_q    <= p4_d;
      skv_q   <= skv_d;
      ski_q   <= ski_d;
      skp_q   <= skp_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
`endif

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q & AMASK;
  assign InstrF   = valid_q ? instr_q : NOP_INSTR;
  assign PCF      = pcf_q;
  assign PCPlus4F = p4_q;
  assign ValidF   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: queue of expected PCs, monitor pops
// each consumed instruction; directed reset/stall/redirect/wrap checks.
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ValidF;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        MisalignF;
`endif

  fetch_unit_if mif ();
  assign mif.imem_gnt = mif.imem_req;

  fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (mif.master),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .ValidF    (ValidF)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .MisalignF (MisalignF)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  logic        nx_rst = 1'b0;
  logic        nx_stall = 1'b0;
  logic        nx_redir = 1'b0;
  logic [31:0] nx_tgt = '0;
  logic        force_rv = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          lat = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One cycle: apply inputs and memory response, then record any grant.
  task automatic step();
    @(negedge clk);
    rst_n     = nx_rst;
    StallF    = nx_stall;
    PCSrcE    = nx_redir;
    PCTargetE = nx_tgt;
    mif.imem_rvalid = 1'b0;
    mif.imem_rdata  = '0;
    if (force_rv) begin
      mif.imem_rvalid = 1'b1;
      mif.imem_rdata  = 32'hDEAD_BEEF;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mif.imem_rvalid = 1'b1;
        mif.imem_rdata  = pend_addr ^ KEY;
      end
    end
    #1;
    if (rst_n && mif.imem_req && mif.imem_gnt) begin
      pend_addr = mif.imem_addr;
      pend_cnt  = lat;
    end
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (ValidF === 1'b1 && StallF === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pcf", PCF, 32'hXXXX_XXXX);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pcf", PCF, e);
          chk("sb_instr", InstrF, e ^ KEY);
          chk("sb_pcplus4", PCPlus4F, e + 32'd4);
        end
      end else if (ValidF !== 1'b1) begin
        chk("nop_when_invalid", InstrF, NOP);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    StallF = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = '0;
    mif.imem_rvalid = 1'b0;
    mif.imem_rdata = '0;

    step(); step();
    chk("rst_valid", {31'b0, ValidF}, 32'd0);
    chk("rst_instr", InstrF, NOP);
    chk("rst_pcf", PCF, 32'd0);
    chk("rst_pcp4", PCPlus4F, 32'd0);
    chk("rst_req", {31'b0, mif.imem_req}, 32'd0);

    nx_rst = 1'b1;
    step();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    step();
    chk("c1_req", {31'b0, mif.imem_req}, 32'd1);
    chk("c1_addr", mif.imem_addr, 32'h0);
    step();
    chk("c2_valid", {31'b0, ValidF}, 32'd0);
    step();
    chk("c3_valid", {31'b0, ValidF}, 32'd1);
    chk("c3_pcf", PCF, 32'h0);
    step();

    nx_stall = 1'b1;
    step();
    chk("stall1_req", {31'b0, mif.imem_req}, 32'd0);
    step();
    chk("stall2_req", {31'b0, mif.imem_req}, 32'd0);
    step();
    chk("stall3_req", {31'b0, mif.imem_req}, 32'd0);
    chk("stall_pcf", PCF, 32'h8);
    nx_stall = 1'b0;
    step();
    step();
    chk("skid_pcf", PCF, 32'hC);

    nx_rst = 1'b0;
    pend_cnt = 0;
    force_rv = 1'b1;
    step();
    chk("mid_rst_valid", {31'b0, ValidF}, 32'd0);
    chk("mid_rst_instr", InstrF, NOP);
    chk("mid_rst_pcf", PCF, 32'd0);
    chk("mid_rst_req", {31'b0, mif.imem_req}, 32'd0);
    nx_rst = 1'b1;
    step();
    force_rv = 1'b0;
    chk("late_rv_valid", {31'b0, ValidF}, 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h100);
    step();
    chk("post_rst_req", {31'b0, mif.imem_req}, 32'd1);
    chk("post_rst_addr", mif.imem_addr, 32'h0);
    step(); step(); step();
    lat = 3;
    step(); step();

    nx_redir = 1'b1;
    nx_tgt = 32'h100;
    step();
    nx_redir = 1'b0;
    step();
    step();
    chk("redir_req", {31'b0, mif.imem_req}, 32'd1);
    chk("redir_addr", mif.imem_addr, 32'h100);
    step(); step(); step(); step(); step();

    nx_redir = 1'b1;
    nx_tgt = 32'h40;
    step();
    chk("rv_redir_rvalid", {31'b0, mif.imem_rvalid}, 32'd1);
    nx_redir = 1'b0;
    lat = 1;
    exp_q.push_back(32'h40);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    step();
    chk("rv_redir_req", {31'b0, mif.imem_req}, 32'd1);
    chk("rv_redir_addr", mif.imem_addr, 32'h40);
    step();

    nx_redir = 1'b1;
    nx_tgt = 32'hFFFF_FFFC;
    step();
    nx_redir = 1'b0;
    step();
    chk("wrap_addr", mif.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_next_addr", mif.imem_addr, 32'h0);
    step();
    chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4F, 32'h0);
    step();

    #5;
    chk("sb_leftover", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
